// File: rtl/folded_dot_product_engine_if.sv
// Handshake and data bundle between the dot-product engine and its producers/consumer.
// The engine takes the slave modport; the row/command source and result sink use master.
interface folded_dot_product_engine_if #(
    parameter int NO_OF_UNITS     = 8,
    parameter int ELEMENT_WIDTH   = 16,
    parameter int ACC_WIDTH       = 40,
    parameter int MULTIPLES_WIDTH = 4
);
    logic                                   cmd_valid;
    logic                                   cmd_ready;
    logic [MULTIPLES_WIDTH-1:0]             no_of_multiples;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   first_row_input;
    logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   second_row_input;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [ACC_WIDTH-1:0]                   dot_product_output;
    logic                                   overflow;
    logic                                   busy;

    modport master (
        output cmd_valid, no_of_multiples, in_valid, first_row_input, second_row_input, out_ready,
        input  cmd_ready, in_ready, out_valid, dot_product_output, overflow, busy
    );

    modport slave (
        input  cmd_valid, no_of_multiples, in_valid, first_row_input, second_row_input, out_ready,
        output cmd_ready, in_ready, out_valid, dot_product_output, overflow, busy
    );
endinterface

// File: rtl/folded_dot_product_engine.sv
// Signed dot product over N packages with NO_OF_UNITS/FOLD multipliers; FOLD MAC cycles per package.
// Result held in OUT until out_ready; command FIFO throttles via cmd_ready, package input via in_ready.
module folded_dot_product_engine #(
    parameter int NO_OF_UNITS     = 8,
    parameter int FOLD            = 2,
    parameter int ELEMENT_WIDTH   = 16,
    parameter int ACC_WIDTH       = 40,
    parameter int MULTIPLES_WIDTH = 4,
    parameter int CMD_DEPTH       = 4,
    parameter int SATURATE        = 0
) (
    input  logic clk,
    input  logic reset,
    folded_dot_product_engine_if.slave bus
);
    localparam int LANES   = NO_OF_UNITS / FOLD;
    localparam int ROW_W   = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int PROD_W  = 2 * ELEMENT_WIDTH;
    localparam int SUM_W   = ACC_WIDTH + $clog2(LANES) + 1;
    localparam int PTR_W   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W   = $clog2(CMD_DEPTH + 1);
    localparam int SLICE_W = (FOLD > 1) ? $clog2(FOLD) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;

    state_t                      state;
    logic [MULTIPLES_WIDTH-1:0]  n_q;
    logic [MULTIPLES_WIDTH-1:0]  pkg_cnt;
    logic [SLICE_W-1:0]          slice;
    logic [ROW_W-1:0]            a_q;
    logic [ROW_W-1:0]            b_q;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        ovf_q;

    logic [MULTIPLES_WIDTH-1:0]  cmd_mem [CMD_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            cmd_count;
    logic                        ready_en;
    logic                        push;
    logic                        pop;

    // ready_en keeps cmd_ready low until the first edge after reset releases
    assign bus.cmd_ready = ready_en && (cmd_count != CNT_W'(CMD_DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (cmd_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr] <= bus.no_of_multiples;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + CNT_W'(1);
                2'b01:   cmd_count <= cmd_count - CNT_W'(1);
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // The latched rows shift left each MAC cycle, so the active slice always sits in the MSB lanes.
    logic signed [PROD_W-1:0]    prods [LANES];
    logic signed [SUM_W-1:0]     slice_sum;
    logic signed [SUM_W-1:0]     acc_wide;
    logic [SUM_W-ACC_WIDTH:0]    acc_top;
    logic                        step_ovf;
    logic signed [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        slice_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prods[i]  = $signed(a_q[ROW_W-1-i*ELEMENT_WIDTH -: ELEMENT_WIDTH])
                      * $signed(b_q[ROW_W-1-i*ELEMENT_WIDTH -: ELEMENT_WIDTH]);
            slice_sum = slice_sum + SUM_W'(prods[i]);
        end
        // Overflow means the wide sum no longer fits the accumulator: its upper bits disagree.
        acc_wide = SUM_W'(acc) + slice_sum;
        acc_top  = acc_wide[SUM_W-1:ACC_WIDTH-1];
        step_ovf = !((&acc_top) || !(|acc_top));
        if (step_ovf && (SATURATE != 0)) begin
            acc_next = acc_wide[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            acc_next = acc_wide[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            n_q     <= '0;
            pkg_cnt <= '0;
            slice   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        n_q     <= cmd_mem[rd_ptr];
                        pkg_cnt <= '0;
                        acc     <= '0;
                        ovf_q   <= 1'b0;
                        state   <= (cmd_mem[rd_ptr] == '0) ? OUT : FETCH;
                    end
                end
                FETCH: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.first_row_input;
                        b_q   <= bus.second_row_input;
                        slice <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    a_q <= a_q << (LANES * ELEMENT_WIDTH);
                    b_q <= b_q << (LANES * ELEMENT_WIDTH);
                    if (step_ovf) begin
                        ovf_q <= 1'b1;
                    end
                    if (slice == SLICE_W'(FOLD - 1)) begin
                        slice <= '0;
                        if (pkg_cnt == n_q - MULTIPLES_WIDTH'(1)) begin
                            state <= OUT;
                        end else begin
                            pkg_cnt <= pkg_cnt + MULTIPLES_WIDTH'(1);
                            state   <= FETCH;
                        end
                    end else begin
                        slice <= slice + SLICE_W'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready           = (state == FETCH);
    assign bus.out_valid          = (state == OUT);
    assign bus.busy               = (state != IDLE);
    assign bus.dot_product_output = acc;
    assign bus.overflow           = ovf_q;
endmodule

// File: doc/folded_dot_product_engine.md
# folded_dot_product_engine

- Parametrised successor of the fixed 8-lane dot-product unit.
- Computes signed fixed-point dot products of two row vectors delivered as a sequence of `NO_OF_UNITS`-lane packages; the package count per dot product is queued ahead of the data in a command FIFO.
- Multipliers are time-folded (`NO_OF_UNITS/FOLD` physical multipliers, `FOLD` cycles per package). Results go into a wide accumulator with optional saturation.
- Sits between the row/vector memories and the solver control; all handshakes are valid/ready.

## Interface
Parameters:
- `NO_OF_UNITS`, 8 — lanes per package; must be divisible by `FOLD`.
- `FOLD`, 2 — cycles per package; lanes handled per cycle = `NO_OF_UNITS/FOLD`.
- `ELEMENT_WIDTH`, 16 — signed two's-complement element width.
- `ACC_WIDTH`, 40 — accumulator/result width; must be ≥ 2*`ELEMENT_WIDTH`.
- `MULTIPLES_WIDTH`, 4 — width of the package-count field.
- `CMD_DEPTH`, 4 — command FIFO depth; power of two.
- `SATURATE`, 0 — 1 selects clamp-on-overflow, 0 selects wrap.

Ports:
- `clk` in 1 — the single clock; all state changes on posedge.
- `reset` in 1 — one clock; reset is asynchronous and active-high.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — FIFO not full.
- `no_of_multiples` in `MULTIPLES_WIDTH` — packages in the next dot product.
- `in_valid` in 1 — package present.
- `in_ready` out 1 — engine accepts a package this cycle.
- `first_row_input` in `NO_OF_UNITS*ELEMENT_WIDTH` — lane 0 in the MSBs.
- `second_row_input` in `NO_OF_UNITS*ELEMENT_WIDTH` — lane 0 in the MSBs.
- `out_valid` out 1 — result held.
- `out_ready` in 1 — consumer takes the result.
- `dot_product_output` out `ACC_WIDTH` — signed result.
- `overflow` out 1 — sticky per result; accumulator overflowed during this dot product.
- `busy` out 1 — FSM not in IDLE.

## Operation
Command FIFO:
- Push on `cmd_valid && cmd_ready`; pop when IDLE and the FIFO is non-empty.
- Pointers wrap modulo `CMD_DEPTH`.
- Simultaneous push and pop leaves the count unchanged.
- `cmd_ready` = !full, registered-count based. A pop in the same cycle does not enable a push into a full FIFO.

FSM states: IDLE, FETCH, MAC, OUT.
- IDLE: on a non-empty FIFO, pop; `N`=head; clear accumulator, package counter and `overflow`.
  - `N`==0 → OUT with result 0.
  - Otherwise → FETCH.
- FETCH: `in_ready`=1 (combinational from state only).
  - On `in_valid`: latch both rows, slice=0 → MAC.
  - With `in_valid`=0: stay in FETCH indefinitely.
- MAC: one slice per cycle; slice s covers lanes s*L .. s*L+L-1, where L=`NO_OF_UNITS/FOLD`. Slice 0 holds the MSB lanes.
  - Per cycle: `acc <= acc + sum(a[i]*b[i])` over the slice.
  - Products are full 2*`ELEMENT_WIDTH` signed values, sign-extended to `ACC_WIDTH` before the adder tree.
  - At slice `FOLD`-1: if package counter == `N`-1 → OUT, else counter+1 → FETCH.
- OUT: `out_valid`=1; `dot_product_output`=acc is stable while waiting. On `out_ready` → IDLE.

Overflow rule (signed overflow of any accumulate step):
- Sets `overflow` (sticky until the next IDLE pop).
- `SATURATE`=1: acc clamps to +2^(`ACC_WIDTH`-1)-1 or -2^(`ACC_WIDTH`-1) and continues from the clamped value.
- `SATURATE`=0: acc wraps.

Reset (asynchronous; also mid-operation):
- Aborts the dot product and empties the FIFO.
- Returns to IDLE; accumulator = 0.
- All outputs 0: `cmd_ready`, `in_ready`, `out_valid`, `dot_product_output`, `overflow`, `busy`.
- `cmd_ready` rises on the first posedge after reset deasserts.

## Timing
- Command push at edge c → popped at c+1 if the engine is IDLE → FETCH visible from c+1.
- Package accept at edge p → MAC occupies p+1 .. p+`FOLD`.
- Next `in_ready` at p+`FOLD` (after the last MAC edge); throughput is one package per `FOLD`+1 cycles.
- Last package accept at p → `out_valid` high after edge p+`FOLD`.
- `N`=0 → `out_valid` high one edge after the pop.
- OUT→IDLE costs one cycle; the next command pops on the following edge.
- `busy`=1 in FETCH, MAC and OUT.

## Test plan
Directed scenarios use defaults unless stated.
- Single package: `N`=1; all first-row lanes=1, all second-row lanes=2 → `dot_product_output`=16, `overflow`=0, `out_valid` exactly 2 edges after the accept.
- Signed multi-package: `N`=3; lanes 1..8 times all -1, three times → result -108 (0xFF_FFFF_FF94); `in_ready` low for exactly 2 cycles after each accept.
- Zero count: push `N`=0 → `out_valid`=1 with result 0 one edge after the pop; no `in_ready` pulse.
- Backpressure and FIFO full: hold `out_ready`=0 for 10 cycles while pushing 5 commands.
  - Result held stable throughout.
  - `cmd_ready` drops after the 4th push.
  - After `out_ready`=1, one pop frees a slot and `cmd_ready` reasserts.
- Saturation: `SATURATE`=1, `ACC_WIDTH`=32, `N`=2, all lanes 0x7FFF×0x7FFF → result 0x7FFFFFFF, `overflow`=1. Same stimulus with `SATURATE`=0 → wrapped value (acc mod 2^32), `overflow`=1.
- Reset mid-MAC: assert `reset` during slice 1 of package 2 of `N`=3, with 2 commands queued.
  - Outputs go to 0 asynchronously.
  - After release, no stale pop occurs.
  - A fresh `N`=1 command yields the correct result.
